// File: rtl/x1_row_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// x1_row_sequencer
//   Wishbone master expanding one row PROGRAM/READ request into the 32
//   per-cell shim commands, then polling back READ results in issue order.
//   Rev 1.0 - initial release
// ============================================================================
module x1_row_sequencer #(
  parameter logic [31:0] X1_ADDR    = 32'h3000_000C,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        op,
  input  logic [4:0]  row,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int                PCW         = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0]    c_poll_last = PCW'(POLL_LIMIT - 1);
  localparam logic [31:0]       c_not_ready = 32'hDEAD_C0DE;
  localparam logic [4:0]        c_last_col  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_GAP_ISSUE = 3'd2,
    S_POLL      = 3'd3,
    S_GAP_POLL  = 3'd4,
    S_FIN       = 3'd5,
    S_ABORT     = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic           op_q, op_d;
  logic [4:0]     row_q, row_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [4:0]     col_q, col_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [31:0]    shadow_q, shadow_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           cyc_q, cyc_d;
  logic           stb_q, stb_d;
  logic           we_q, we_d;
  logic [31:0]    dat_q, dat_d;
  logic           ack_seen;

  // Command layout: {mode, row, col, 12'b0, data}; PROGRAM drives a full-scale cell value.
  function automatic logic [31:0] cmd_word(input logic prog, input logic [4:0] r,
                                           input logic [4:0] c, input logic bit_v);
    return {(prog ? 2'b11 : 2'b01), r, c, 12'h000, ((prog && bit_v) ? 8'hFF : 8'h00)};
  endfunction

  assign ack_seen = wbm_ack_i && stb_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    row_d      = row_q;
    wdata_d    = wdata_q;
    col_d      = col_q;
    poll_cnt_d = poll_cnt_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    dat_d      = dat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          row_d      = row;
          wdata_d    = wdata;
          col_d      = 5'd0;
          poll_cnt_d = '0;
          shadow_d   = 32'h0;
          busy_d     = 1'b1;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          we_d       = 1'b1;
          dat_d      = cmd_word(op, row, 5'd0, wdata[0]);
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (ack_seen) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (col_q == c_last_col) begin
            if (op_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_FIN;
            end else begin
              // All 32 reads sit in the core FIFOs; results now drain from column 0.
              col_d   = 5'd0;
              state_d = S_GAP_POLL;
            end
          end else begin
            col_d   = col_q + 5'd1;
            state_d = S_GAP_ISSUE;
          end
        end
      end

      S_GAP_ISSUE: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        dat_d   = cmd_word(op_q, row_q, col_q, wdata_q[col_q]);
        state_d = S_ISSUE;
      end

      S_POLL: begin
        if (ack_seen) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (wbm_dat_i == c_not_ready) begin
            if (poll_cnt_q == c_poll_last) begin
              poll_cnt_d = '0;
              err_d      = 1'b1;
              busy_d     = 1'b0;
              state_d    = S_ABORT;
            end else begin
              poll_cnt_d = poll_cnt_q + 1'b1;
              state_d    = S_GAP_POLL;
            end
          end else begin
            shadow_d[col_q] = wbm_dat_i[0];
            poll_cnt_d      = '0;
            if (col_q == c_last_col) begin
              rdata_d = shadow_d;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_FIN;
            end else begin
              col_d   = col_q + 5'd1;
              state_d = S_GAP_POLL;
            end
          end
        end
      end

      S_GAP_POLL: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        dat_d   = 32'h0;
        state_d = S_POLL;
      end

      S_FIN:   state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      row_q      <= 5'd0;
      wdata_q    <= 32'h0;
      col_q      <= 5'd0;
      poll_cnt_q <= '0;
      shadow_q   <= 32'h0;
      rdata_q    <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      dat_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      row_q      <= row_d;
      wdata_q    <= wdata_d;
      col_q      <= col_d;
      poll_cnt_q <= poll_cnt_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = X1_ADDR;
  assign wbm_dat_o = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_x1_row_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_x1_row_sequencer
//   Directed + randomized bench: behavioural X1 shim slave (cell array, result
//   FIFO, random not-ready words and stalls) and a row-level reference memory.
//   Rev 1.0 - initial release
// ============================================================================
module tb_x1_row_sequencer;

  localparam logic [31:0] X1_ADDR    = 32'h3000_000C;
  localparam int          POLL_LIMIT = 4;
  localparam logic [31:0] DEAD       = 32'hDEAD_C0DE;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start    = 1'b0;
  logic        op       = 1'b0;
  logic [4:0]  row      = 5'd0;
  logic [31:0] wdata    = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;

  x1_row_sequencer #(.X1_ADDR(X1_ADDR), .POLL_LIMIT(POLL_LIMIT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .op(op), .row(row),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what each row should hold, tracked purely at row granularity.
  logic [31:0] ref_rows [32];

  // Shim model state
  logic [31:0] shim_mem [32];
  bit          rq [$];
  int          exp_k, consec, dead_acks, wait_cnt;
  logic        exp_op;
  logic [4:0]  exp_row;
  logic [31:0] exp_wdata;
  logic [31:0] wlog [32];
  bit          force_dead = 0;
  int          hold_col = -1;
  int          hold_len = 0;
  bit          req_active = 0;
  logic [32:0] cap_req;

  task automatic respond();
    logic [31:0] exp_word, d;
    logic [4:0]  kc, r, c;
    bit          b;
    chk("adr_sel", {28'h0, wbm_sel_o, wbm_adr_o}, {28'h0, 4'hF, X1_ADDR});
    if (exp_k < 32) begin
      kc = exp_k[4:0];
      exp_word = {(exp_op ? 2'b11 : 2'b01), exp_row, kc, 12'h000,
                  ((exp_op && exp_wdata[exp_k]) ? 8'hFF : 8'h00)};
      chk("we_issue", 64'(wbm_we_o), 64'd1);
      chk("cmd_word", 64'(wbm_dat_o), 64'(exp_word));
      wlog[exp_k] = wbm_dat_o;
      exp_k++;
      r = wbm_dat_o[29:25];
      c = wbm_dat_o[24:20];
      if (wbm_dat_o[31:30] == 2'b11) shim_mem[r][c] = (wbm_dat_o[7:0] != 8'h00);
      else if (wbm_dat_o[31:30] == 2'b01) rq.push_back(shim_mem[r][c]);
      wbm_dat_i = $urandom;
    end else begin
      chk("we_poll", 64'(wbm_we_o), 64'd0);
      if (force_dead || rq.size() == 0 || (consec < 2 && $urandom_range(0, 3) == 0)) begin
        wbm_dat_i = DEAD;
        consec++;
        dead_acks++;
      end else begin
        b = rq.pop_front();
        d = ($urandom & 32'hFFFF_FFFE) | 32'(b);
        if (d == DEAD) d = d ^ 32'h2;
        wbm_dat_i = d;
        consec = 0;
      end
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_ack_i  = 1'b0;
      req_active = 0;
    end else if (wbm_ack_i) begin
      wbm_ack_i  = 1'b0;
      req_active = 0;
      chk("idle_gap", {62'h0, wbm_cyc_o, wbm_stb_o}, 64'd0);
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (!req_active) begin
        req_active = 1;
        cap_req = {wbm_we_o, wbm_dat_o};
        if (hold_col >= 0 && exp_k == hold_col && wbm_we_o) begin
          wait_cnt = hold_len;
          hold_col = -1;
        end else begin
          wait_cnt = $urandom_range(0, 2);
        end
      end else begin
        chk("req_stable", 64'({wbm_we_o, wbm_dat_o}), 64'(cap_req));
      end
      if (wait_cnt > 0) wait_cnt--;
      else begin
        respond();
        wbm_ack_i = 1'b1;
      end
    end else begin
      req_active = 0;
    end
  end

  task automatic run_op(input logic o, input logic [4:0] r, input logic [31:0] w,
                        input bit expect_err);
    int n;
    bit busy_ok;
    exp_op = o; exp_row = r; exp_wdata = w; exp_k = 0; consec = 0; dead_acks = 0;
    @(negedge wb_clk_i);
    start = 1'b1; op = o; row = r; wdata = w;
    @(negedge wb_clk_i);
    start = 1'b0; op = 1'($urandom); row = 5'($urandom); wdata = $urandom;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    busy_ok = 1;
    while (!done && !err && n < 6000) begin
      if (!busy) busy_ok = 0;
      @(negedge wb_clk_i);
      n++;
    end
    chk("op_timeout", 64'(n < 6000), 64'd1);
    chk("busy_throughout", 64'(busy_ok), 64'd1);
    chk("done_err", {62'h0, done, err}, expect_err ? 64'd1 : 64'd2);
    chk("busy_low_at_end", 64'(busy), 64'd0);
    chk("cmd_count", 64'(exp_k), 64'd32);
    @(negedge wb_clk_i);
    chk("pulse_one_cycle", {61'h0, done, err, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] w, prev;
    logic [4:0]  r;
    int          n;
    bit          quiet;

    for (int i = 0; i < 32; i++) begin
      ref_rows[i] = 32'h0;
      shim_mem[i] = 32'h0;
      wlog[i]     = 32'h0;
    end

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("reset_ctrl", {58'h0, busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    wb_rst_i = 1'b0;

    // PROGRAM row 5 with known pattern, then read it back
    run_op(1'b1, 5'd5, 32'h8000_0001, 0);
    ref_rows[5] = 32'h8000_0001;
    chk("col0_word", 64'(wlog[0]), 64'h0000_0000_CA00_00FF);
    chk("col1_word", 64'(wlog[1]), 64'h0000_0000_CA10_0000);
    chk("col31_word", 64'(wlog[31]), 64'h0000_0000_CBF0_00FF);

    run_op(1'b0, 5'd5, 32'h0, 0);
    chk("read_row5", 64'(rdata), 64'h8000_0001);

    run_op(1'b0, 5'd0, 32'hFFFF_FFFF, 0);
    chk("read_row0", 64'(rdata), 64'h0);

    // Random program/read pairs
    for (int i = 0; i < 4; i++) begin
      r = 5'($urandom_range(1, 31));
      w = $urandom;
      run_op(1'b1, r, w, 0);
      ref_rows[r] = w;
      r = 5'($urandom_range(0, 31));
      run_op(1'b0, r, $urandom, 0);
      chk("read_random", 64'(rdata), 64'(ref_rows[r]));
    end

    // Never-ready result stream: abort after POLL_LIMIT not-ready words
    prev = rdata;
    force_dead = 1;
    run_op(1'b0, 5'd5, 32'h0, 1);
    chk("abort_dead_count", 64'(dead_acks), 64'(POLL_LIMIT));
    chk("abort_rdata_held", 64'(rdata), 64'(prev));
    quiet = 1;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbm_stb_o || wbm_cyc_o) quiet = 0;
    end
    chk("abort_bus_quiet", 64'(quiet), 64'd1);
    force_dead = 0;
    rq.delete();

    // Reset while column 10 is on the bus
    exp_op = 1'b1; exp_row = 5'd9; exp_wdata = 32'hFFFF_FFFF; exp_k = 0;
    hold_col = 10; hold_len = 100000;
    @(negedge wb_clk_i);
    start = 1'b1; op = 1'b1; row = 5'd9; wdata = 32'hFFFF_FFFF;
    @(negedge wb_clk_i);
    start = 1'b0;
    n = 0;
    while (!(wbm_stb_o && wbm_dat_o[24:20] == 5'd10) && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("reach_col10", 64'(n < 500), 64'd1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("mid_reset", {61'h0, wbm_cyc_o, wbm_stb_o, busy}, 64'd0);
    wb_rst_i = 1'b0;
    hold_col = -1;
    quiet = 1;
    repeat (5) begin
      @(negedge wb_clk_i);
      if (wbm_stb_o || wbm_cyc_o || busy) quiet = 0;
    end
    chk("post_reset_quiet", 64'(quiet), 64'd1);
    w = $urandom;
    run_op(1'b1, 5'd9, w, 0);
    ref_rows[9] = w;
    run_op(1'b0, 5'd9, 32'h0, 0);
    chk("read_row9", 64'(rdata), 64'(ref_rows[9]));

    // 300-cycle stall on one write, plus a start pulse while busy
    hold_col = 7; hold_len = 300;
    w = $urandom;
    fork
      run_op(1'b1, 5'd12, w, 0);
      begin
        repeat (60) @(negedge wb_clk_i);
        start = 1'b1; op = 1'b0; row = 5'd3;
        @(negedge wb_clk_i);
        start = 1'b0;
      end
    join
    ref_rows[12] = w;
    run_op(1'b0, 5'd12, 32'h0, 0);
    chk("read_row12", 64'(rdata), 64'(ref_rows[12]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x1_row_sequencer.md
Name: x1_row_sequencer

Overview:
- Wishbone master that sits directly upstream of the Neuromorphic_X1 shim and drives its single command/result address.
- Converts a one-shot row request into the 32 per-cell commands the array needs:
  - PROGRAM: writes a whole 32-bit weight row.
  - READ: fetches a whole row back as one 32-bit word.
- Handles the shim's result protocol: result pops, DEAD_C0DE "not ready" words, and back-pressure while its command FIFO is full.

Parameters:
- X1_ADDR, 32'h3000_000C, address driven on every transaction.
- POLL_LIMIT, 1024, maximum consecutive DEAD_C0DE responses tolerated per result before an error abort.

Ports:
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start  in  1  1-cycle request pulse; sampled only in IDLE.
- op  in  1  1 = PROGRAM row, 0 = READ row; latched on start.
- row  in  5  target row; latched on start.
- wdata  in  32  row weights; bit c goes to column c; latched on start.
- busy  out  1  high from the cycle after an accepted start until done/err.
- done  out  1  1-cycle pulse on successful completion.
- err  out  1  1-cycle pulse on a POLL_LIMIT abort; coincides with done=0.
- rdata  out  32  assembled row (READ only); updated when done pulses; holds otherwise.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  byte select; constant 4'hF.
- wbm_adr_o  out  32  address; constant X1_ADDR.
- wbm_dat_o  out  32  command word.
- wbm_dat_i  in  32  result word.
- wbm_ack_i  in  1  acknowledge.

Behaviour:
- Reset values (wb_rst_i=1 at a clock edge):
  - busy, done, err, cyc, stb, we = 0; rdata = 0.
  - Column counter = 0, poll counter = 0, state = IDLE.
  - Reset mid-transaction: cyc and stb drop on that same edge; no further commands are issued.
- Command word:
  - {mode[1:0], row[4:0], col[4:0], 12'b0, data[7:0]}.
  - mode = 2'b11 for PROGRAM, 2'b01 for READ.
  - PROGRAM data = 8'hFF when wdata[col]=1, else 8'h00. READ data = 8'h00.
- Bus handshake:
  - cyc, stb, we, dat are held stable until the ack edge.
  - The cycle after an ack, cyc and stb are 0; this idle gap is mandatory.
  - The next request can therefore start no earlier than 2 cycles after the previous ack.
  - There is no ack timeout. Command-FIFO-full back-pressure is a legal indefinite stall.
- State machine:
  - IDLE: start=1 latches op/row/wdata, clears col, sets busy, goes to ISSUE. Start while busy is ignored.
  - ISSUE: write the command for col.
    - On ack with col=31: PROGRAM goes to FIN; READ clears col and goes to GAP_POLL.
    - On ack otherwise: col+1, go to GAP_ISSUE.
  - GAP_ISSUE: one idle cycle, then ISSUE.
  - POLL: read transaction (we=0).
    - On ack with wbm_dat_i == 32'hDEAD_C0DE: poll counter +1.
      - If poll counter reaches POLL_LIMIT: go to ABORT.
      - Else go to GAP_POLL; col is unchanged.
    - On ack with any other value: shadow[col] = wbm_dat_i[0]; clear poll counter.
      - If col=31: go to FIN. Else col+1, go to GAP_POLL.
  - GAP_POLL: one idle cycle, then POLL.
  - FIN: done=1 for one cycle; for READ, rdata = shadow (same cycle); busy=0; return to IDLE.
  - ABORT: err=1 for one cycle; busy=0; rdata unchanged; return to IDLE.
- Ordering:
  - Results pop in issue order, so result k belongs to column k.
  - PROGRAM done means all 32 commands were accepted into the core FIFO, not that the cells are written. A later READ is ordered behind them by the core FIFO.
- Boundaries:
  - col wraps are never taken; the counter stops at 31.
  - An ack seen while stb=0 is ignored.
  - 32 READ commands exactly fill both 32-deep core FIFOs, so issuing all of them before polling cannot deadlock.

Test Plan:
- Reset, then PROGRAM row=5, wdata=32'h8000_0001:
  - 32 writes; col0 word = 32'hCA00_00FF, col1 word = 32'hCA10_0000, col31 word = 32'hCBF0_00FF.
  - done pulses once; busy is high throughout the op.
- After that program, READ row=5:
  - 32 read commands followed by polls; DEAD_C0DE responses are retried.
  - done pulses with rdata = 32'h8000_0001.
- READ of untouched row=0 → rdata = 32'h0000_0000. Also check the idle gap: stb=0 for exactly the cycle after every ack.
- POLL_LIMIT=4, slave model returning only DEAD_C0DE after the issue phase → err pulses after the 4th DEAD_C0DE ack; done=0; rdata unchanged.
- Assert wb_rst_i in the middle of ISSUE (col=10) → next cycle cyc=stb=busy=0. A new start then restarts from col 0.
- Slave withholds ack for 300 cycles on one write → request held stable the whole time with no error; completes normally afterwards. A start pulse during busy has no effect.
